// File: rtl/stream_cmd_memory.sv
// Command-driven scratch memory on a valid/ready stream: single-word and burst
// store/load, with read data returned through a 2-entry skid buffer.
module stream_cmd_memory #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 14,
  localparam int CMD_W  = 2 + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CMD_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              cmd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] OP_STORE  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_BLOAD  = 2'b10;
  localparam logic [1:0] OP_BSTORE = 2'b11;
  localparam logic [DATA_W:0]   REM_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WBURST = 2'd1, READ = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W:0]     rem_q, rem_nxt;
  logic                ready_q;
  logic                err_q, err_nxt;

  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_field;
  logic                in_fire, out_fire;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_issue, rd_free, rd_done;
  logic                rd_inflight_q, rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   buf_data [2];
  logic                buf_last [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          buf_cnt;

  assign cmd_op    = in_data[CMD_W-1 -: 2];
  assign cmd_addr  = in_data[CMD_W-3 -: ADDR_W];
  assign cmd_field = in_data[DATA_W-1:0];

  // Both streams transfer on a rising edge where valid && ready; a producer
  // holding valid keeps its data stable until that edge.
  assign in_ready  = ready_q && (state != READ);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign out_fire  = out_valid && out_ready;
  assign cmd_err   = err_q;

  // A read may launch only if the buffer still has a slot once the in-flight
  // word lands, crediting the word leaving this cycle.
  assign rd_free = ({1'b0, buf_cnt} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, out_fire});
  assign rd_done = (rem_q == '0) && !rd_inflight_q &&
                   ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && out_fire));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    err_nxt   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = cmd_field;
    rd_issue  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_fire) begin
          addr_nxt = cmd_addr;
          rem_nxt  = {1'b0, cmd_field} + REM_ONE;
          unique case (cmd_op)
            OP_STORE: begin
              mem_we    = 1'b1;
              mem_waddr = cmd_addr;
            end
            OP_LOAD: begin
              rem_nxt   = REM_ONE;
              state_nxt = READ;
            end
            OP_BLOAD: state_nxt = READ;
            default:  state_nxt = WBURST;
          endcase
        end
      end
      WBURST: begin
        if (in_fire) begin
          mem_we   = 1'b1;
          addr_nxt = addr_q + ADDR_ONE;
          rem_nxt  = rem_q - REM_ONE;
          if (in_last || (rem_q == REM_ONE)) state_nxt = IDLE;
          // Early end and missing end are both a disagreement between in_last and the count.
          err_nxt = in_last != (rem_q == REM_ONE);
        end
      end
      READ: begin
        rd_issue = (rem_q != '0) && rd_free;
        if (rd_issue) begin
          addr_nxt = addr_q + ADDR_ONE;
          rem_nxt  = rem_q - REM_ONE;
        end
        if (rd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      ready_q <= 1'b1;
      err_q   <= err_nxt;
    end
  end

  // Memory array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we && rstn) mem[mem_waddr] <= mem_wdata;
    if (rd_issue) rd_data_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      rd_inflight_q <= rd_issue;
      if (rd_issue) rd_last_q <= (rem_q == REM_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (rd_inflight_q) begin
        buf_data[wr_ptr] <= rd_data_q;
        buf_last[wr_ptr] <= rd_last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, rd_inflight_q} - {1'b0, out_fire};
    end
  end

endmodule

// File: doc/stream_cmd_memory.md
# stream_cmd_memory

Parametrised command-driven scratch memory behind a valid/ready stream interface, succeeding the fixed 32-bit single-word STORE/LOAD memory under `sam_wrapper`. Command words on the input stream store or load single words, or move bursts to and from consecutive addresses. Read data returns on the output stream with `out_last` framing each response. The output path is fully back-pressurable and sustains one word per cycle.

## Interface
Parameters:
- `DATA_W`, 16: memory word width and width of the command data/length field.
- `ADDR_W`, 14: address width; depth is 2**ADDR_W words.
- `CMD_W`, 2+ADDR_W+DATA_W (32): input word width; derived, not overridable.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `in_data`  in  CMD_W  command or burst payload word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data`.
- `in_last`  in  1  marks the final payload word of a BURST_STORE; ignored on command words.
- `out_data`  out  DATA_W  read data.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_last`  out  1  final word of a LOAD or BURST_LOAD response.
- `cmd_err`  out  1  one-cycle pulse on a framing error.

## Operation
- Command fields: op=[CMD_W-1:CMD_W-2], addr=[CMD_W-3:DATA_W], field=[DATA_W-1:0].
- op 00 STORE: mem[addr] = field.
- op 01 LOAD: one word, mem[addr], is returned with `out_last`=1.
- op 10 BURST_LOAD: N = field+1 words are returned from addr, addr+1, and so on. `out_last` is asserted on word N only.
- op 11 BURST_STORE: the next N = field+1 accepted words are payload. Each payload's [DATA_W-1:0] is written to addr, addr+1, and so on.
- Addresses wrap modulo 2**ADDR_W, in both read and write bursts.
- FSM states:
  - IDLE: accepts commands. STORE completes here; LOAD and BURST_LOAD go to READ; BURST_STORE goes to WBURST.
  - WBURST: accepts payload words. Returns to IDLE after the Nth word or on `in_last`, whichever comes first.
  - READ: issues N RAM reads. Returns to IDLE once the last read is issued and the output buffer has drained.
- Framing errors pulse `cmd_err` for 1 cycle:
  - Early end: `in_last` arrives on payload k<N. Words 1..k are stored and the burst ends.
  - Missing end: payload N arrives with `in_last`=0. All N words are stored and the burst ends.
- Output buffer: RAM read latency is 1 cycle, so a 2-entry skid buffer is required. A read is issued only when the buffer has a free slot, counting in-flight reads.
- Memory contents are not reset.

## Timing
- Reset (`rstn`=0 at an edge): state returns to IDLE, and the burst counter and output buffer are cleared.
  - After that edge, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0 and `cmd_err`=0.
  - `in_ready` rises on the first edge with `rstn`=1.
- Reset mid-burst aborts the burst. Words already written are retained, and undelivered read data is discarded.
- A transfer occurs on an edge where valid && ready.
- `in_ready`=1 in IDLE and WBURST, and 0 in READ and during reset.
- `out_valid`, once high, stays high and `out_data`/`out_last` stay stable until accepted.
- A write commits at its accepting edge. A LOAD accepted on the following edge returns the new value.
- LOAD/BURST_LOAD accepted at edge T, with `out_ready` held at 1:
  - word 1 is valid in the cycle after edge T+2;
  - word i is valid after edge T+1+i;
  - `in_ready` returns to 1 after the edge on which the last word is accepted.
- A stall of any length on `out_ready` loses and duplicates no words. Throughput resumes at 1 word per cycle.
- STORE and each BURST_STORE payload word are absorbed at 1 word per cycle.
- `cmd_err` is asserted for exactly the cycle after the offending accepting edge.

## Test plan
- Reset, then STORE mem[5]=0xFEED and STORE mem[20]=0xFACE, then LOAD 5 and LOAD 20 -> outputs are 0xFEED then 0xFACE, each with `out_last`=1; word 1 is valid 2 edges after the command.
- BURST_STORE addr 100, field 3, then payload 0x1,0x2,0x3,0x4 with `in_last` on the 4th; then BURST_LOAD addr 100, field 3 -> outputs are 1,2,3,4, `out_last` only on the 4th word, `cmd_err` never asserted.
- Wrap-around: BURST_STORE addr 0x3FFE, 4 words A,B,C,D; then BURST_LOAD addr 0x3FFE, field 3 -> outputs are A,B,C,D, and mem[0]=C and mem[1]=D.
- Back-pressure: BURST_LOAD of 8 words with `out_ready` toggling 1,0,0,1,... -> all 8 words arrive in order exactly once, outputs stay stable while stalled, and `in_ready` stays 0 until the 8th word is accepted.
- Framing: BURST_STORE field 3 with `in_last` on the 2nd payload -> `cmd_err` pulses once, only 2 words are written, and the next word is decoded as a command. Field 1 with no `in_last` -> `cmd_err` pulses once after the 2nd payload word.
- Reset mid-BURST_LOAD (after 2 of 6 words) -> outputs drop to 0 and `in_ready` rises after release. A subsequent LOAD returns the pre-reset memory contents.
